// File: rtl/cdm_pipe_mul.sv
// Two-stage pipelined carry-disregard multiplier with valid/ready handshakes.
// Approx mode ORs the low CD_BITS product columns and sums the rest without a carry from below.
module cdm_pipe_mul #(
  parameter int W       = 8,
  parameter int CD_BITS = 4,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_p,
  output logic               out_approx,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int PW   = 2 * W;
  localparam int SW   = 2 * W + 1;
  localparam int HALF = W / 2;

  logic            s1_valid;
  logic [PW-1:0]   s1_low;
  logic [SW-1:0]   s1_sum_a;
  logic [SW-1:0]   s1_sum_b;
  logic            s1_approx;
  logic [TAG_W-1:0] s1_tag;

  logic            s2_valid;
  logic [PW-1:0]   s2_p;
  logic            s2_approx;
  logic [TAG_W-1:0] s2_tag;

  logic            s2_adv;
  logic            s1_adv;

  logic [PW-1:0]   low_mask;
  logic [PW-1:0]   row;
  logic [PW-1:0]   contrib;
  logic [PW-1:0]   or_low;
  logic [SW-1:0]   sum_a;
  logic [SW-1:0]   sum_b;
  logic [SW-1:0]   total;
  logic [PW-1:0]   final_p;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;

  // Rows are split into two half-sums; in approx mode each row is pre-shifted
  // right by CD_BITS so no carry can come from the disregarded columns.
  always_comb begin
    low_mask = '0;
    row      = '0;
    contrib  = '0;
    or_low   = '0;
    sum_a    = '0;
    sum_b    = '0;
    for (int unsigned i = 0; i < unsigned'(PW); i++) begin
      low_mask[i] = (i < unsigned'(CD_BITS));
    end
    for (int unsigned j = 0; j < unsigned'(W); j++) begin
      row     = in_b[j] ? (PW'(in_a) << j) : '0;
      contrib = in_approx ? (row >> CD_BITS) : row;
      or_low  = or_low | (row & low_mask);
      if (j < unsigned'(HALF)) begin
        sum_a = sum_a + SW'(contrib);
      end else begin
        sum_b = sum_b + SW'(contrib);
      end
    end
  end

  always_comb begin
    total   = s1_sum_a + s1_sum_b;
    final_p = s1_approx ? (PW'(total << CD_BITS) | s1_low) : PW'(total);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_low    <= '0;
      s1_sum_a  <= '0;
      s1_sum_b  <= '0;
      s1_approx <= 1'b0;
      s1_tag    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_low    <= or_low;
        s1_sum_a  <= sum_a;
        s1_sum_b  <= sum_b;
        s1_approx <= in_approx;
        s1_tag    <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_p      <= '0;
      s2_approx <= 1'b0;
      s2_tag    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p      <= final_p;
        s2_approx <= s1_approx;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_p      = s2_p;
  assign out_approx = s2_approx;
  assign out_tag    = s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (cnt_clr) begin
      approx_cnt <= '0;
    end else if (out_valid && out_ready && out_approx && (approx_cnt != '1)) begin
      approx_cnt <= approx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cdm_pipe_mul.sv
// Directed bench for cdm_pipe_mul (W=8, CD_BITS=4, 3-bit counter to reach saturation quickly).
module tb_cdm_pipe_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_approx;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_approx;
  logic [3:0]  out_tag;
  logic        cnt_clr;
  logic [2:0]  approx_cnt;

  int vecs = 0;
  int errs = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  cdm_pipe_mul #(.W(8), .CD_BITS(4), .TAG_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_approx(out_approx), .out_tag(out_tag),
    .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  localparam logic [7:0]  SA [0:8] = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'h00, 8'hCD, 8'h0F, 8'h0F, 8'h80};
  localparam logic [7:0]  SB [0:8] = '{8'hFF, 8'hFF, 8'h03, 8'h03, 8'hAB, 8'h00, 8'h0F, 8'h0F, 8'h80};
  localparam logic        SM [0:8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] SP [0:8] = '{16'hFE01, 16'hFDDF, 16'h0007, 16'h0009, 16'h0000,
                                       16'h0000, 16'h00BF, 16'h00E1, 16'h4000};

  // Reference straight from the row definition: OR of low 4 columns, carry-free sum above.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [15:0] r;
    logic [15:0] low;
    logic [16:0] hi;
    low = '0;
    hi  = '0;
    if (!m) return 16'(a) * 16'(b);
    for (int j = 0; j < 8; j++) begin
      r   = b[j] ? (16'(a) << j) : 16'h0000;
      low = low | (r & 16'h000F);
      hi  = hi + 17'(r >> 4);
    end
    return 16'(hi << 4) | low;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
    in_tag = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    #3;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    vecs++; if (out_p !== 16'h0000 || out_tag !== 4'h0 || out_approx !== 1'b0) begin
      errs++; $display("FAIL rst_data: got p=%h tag=%h ap=%b want 0", out_p, out_tag, out_approx); end
    vecs++; if (approx_cnt !== 3'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", approx_cnt); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    exp_cnt = 0;
  endtask

  task automatic test_single;
    for (int v = 0; v < 9; v++) begin
      in_a = SA[v]; in_b = SB[v]; in_approx = SM[v]; in_tag = 4'(v + 3);
      in_valid = 1'b1; out_ready = 1'b1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL single_ready[%0d]: got %b want 1", v, in_ready); end
      tick;
      in_valid = 1'b0;
      tick;
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_latency[%0d]: got valid %b want 1", v, out_valid); end
      vecs++; if (out_p !== SP[v] || out_approx !== SM[v] || out_tag !== 4'(v + 3)) begin
        errs++; $display("FAIL single_data[%0d]: got p=%h ap=%b tag=%h want p=%h ap=%b tag=%h",
                         v, out_p, out_approx, out_tag, SP[v], SM[v], 4'(v + 3)); end
      vecs++; if (approx_cnt !== 3'(exp_cnt)) begin errs++; $display("FAIL single_cnt_pre[%0d]: got %0d want %0d", v, approx_cnt, exp_cnt); end
      tick;
      if (SM[v]) exp_cnt++;
      vecs++; if (out_valid !== 1'b0 || approx_cnt !== 3'(exp_cnt)) begin
        errs++; $display("FAIL single_handoff[%0d]: got valid=%b cnt=%0d want valid=0 cnt=%0d", v, out_valid, approx_cnt, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ba [20];
    logic [7:0] bb [20];
    logic       bm [20];
    logic       pend;
    logic [15:0] want;
    for (int i = 0; i < 20; i++) begin
      ba[i] = 8'($urandom_range(0, 255));
      bb[i] = 8'($urandom_range(0, 255));
      bm[i] = (i % 3) != 0;
    end
    ba[0] = 8'hFF; bb[0] = 8'hFF;
    ba[1] = 8'hFF; bb[1] = 8'hFF;
    cnt_clr = 1'b1; tick; cnt_clr = 1'b0; exp_cnt = 0;
    vecs++; if (approx_cnt !== 3'd0) begin errs++; $display("FAIL b2b_clr: got %0d want 0", approx_cnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        in_valid = 1'b1; in_a = ba[c]; in_b = bb[c]; in_approx = bm[c]; in_tag = 4'(c);
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      pend = (c >= 2) && bm[c-2];
      tick;
      if (pend && exp_cnt < 7) exp_cnt++;
      if (c >= 1 && c <= 20) begin
        want = model(ba[c-1], bb[c-1], bm[c-1]);
        vecs++; if (out_valid !== 1'b1 || out_p !== want || out_approx !== bm[c-1] || out_tag !== 4'(c - 1)) begin
          errs++; $display("FAIL b2b_out[%0d]: got v=%b p=%h ap=%b tag=%h want v=1 p=%h ap=%b tag=%h",
                           c - 1, out_valid, out_p, out_approx, out_tag, want, bm[c-1], 4'(c - 1)); end
      end else if (c == 21) begin
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got valid %b want 0", out_valid); end
      end
      vecs++; if (approx_cnt !== 3'(exp_cnt)) begin errs++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", c, approx_cnt, exp_cnt); end
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_approx = 1'b0; in_tag = 4'h1;
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_early: got valid %b want 0", out_valid); end
    in_a = 8'hFF; in_b = 8'hFF; in_approx = 1'b1; in_tag = 4'h2;
    tick;
    in_a = 8'h03; in_b = 8'h03; in_approx = 1'b1; in_tag = 4'h3;
    for (int k = 0; k < 4; k++) begin
      vecs++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_p !== 16'h03A8 || out_tag !== 4'h1 || out_approx !== 1'b0) begin
        errs++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b p=%h tag=%h want rdy=0 v=1 p=03a8 tag=1",
                         k, in_ready, out_valid, out_p, out_tag); end
      if (k < 3) tick;
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_p !== 16'hFDDF || out_approx !== 1'b1 || out_tag !== 4'h2) begin
      errs++; $display("FAIL stall_beat1: got v=%b p=%h tag=%h want v=1 p=fddf tag=2", out_valid, out_p, out_tag); end
    tick;
    vecs++; if (out_valid !== 1'b1 || out_p !== 16'h0007 || out_approx !== 1'b1 || out_tag !== 4'h3) begin
      errs++; $display("FAIL stall_beat2: got v=%b p=%h tag=%h want v=1 p=0007 tag=3", out_valid, out_p, out_tag); end
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_drain: got valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_approx = 1'b1; in_tag = 4'h9;
    tick;
    in_a = 8'h03; in_b = 8'h03; in_tag = 4'hA;
    tick;
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL midrst_pre: got valid %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || out_p !== 16'h0000 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL midrst_out: got v=%b p=%h tag=%h rdy=%b want v=0 p=0 tag=0 rdy=1", out_valid, out_p, out_tag, in_ready); end
    vecs++; if (approx_cnt !== 3'd0) begin errs++; $display("FAIL midrst_cnt: got %0d want 0", approx_cnt); end
    out_ready = 1'b1;
    tick;
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_stale[%0d]: got valid %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_cnt_clr;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h07; in_approx = 1'b1; in_tag = 4'h5;
    tick;
    in_valid = 1'b0;
    tick;
    vecs++; if (out_valid !== 1'b1 || out_p !== 16'h001F) begin
      errs++; $display("FAIL clr_data: got v=%b p=%h want v=1 p=001f", out_valid, out_p); end
    tick;
    vecs++; if (approx_cnt !== 3'd1) begin errs++; $display("FAIL clr_inc: got %0d want 1", approx_cnt); end
    in_valid = 1'b1; in_tag = 4'h6;
    tick;
    in_valid = 1'b0;
    tick;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    vecs++; if (approx_cnt !== 3'd0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL clr_priority: got cnt=%0d v=%b want cnt=0 v=0", approx_cnt, out_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_reset_midstream;
    test_cnt_clr;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
